// File: rtl/instruction_loader.sv
// Loads instruction memory from the UART byte stream: four bytes (MSB first) form one
// word, written to consecutive addresses from 0 until HALT or the last address.
module instruction_loader #(
    parameter int                NB_DATA   = 32,
    parameter int                NB_BYTE   = 8,
    parameter int                NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_INST = 32'hFC000000
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               rx_done_i,
    input  logic [NB_BYTE-1:0] rx_data_i,
    output logic               wr_en_o,
    output logic [NB_ADDR-1:0] wr_addr_o,
    output logic [NB_DATA-1:0] wr_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [NB_ADDR:0]   word_count_o,
    output logic               overflow_o
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_CNT         = $clog2(BYTES_PER_WORD);

    localparam logic [NB_CNT-1:0]  CNT_LAST  = NB_CNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_CNT-1:0]  CNT_ONE   = NB_CNT'(1);
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);
    localparam logic [NB_ADDR:0]   COUNT_ONE = (NB_ADDR + 1)'(1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [NB_DATA-1:0] wr_data_q, wr_data_d;
    logic [NB_ADDR:0]   word_count_q, word_count_d;
    logic               overflow_q, overflow_d;
    logic [NB_DATA-1:0] word_shifted;

    assign word_shifted = {word_q[NB_DATA-NB_BYTE-1:0], rx_data_i};

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        word_d       = word_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    byte_cnt_d   = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            RECV: begin
                if (rx_done_i) begin
                    word_d = word_shifted;
                    if (byte_cnt_q == CNT_LAST) begin
                        // Output copies are loaded here so they stay stable until the next write.
                        state_d    = WRITE;
                        byte_cnt_d = '0;
                        wr_addr_d  = addr_q;
                        wr_data_d  = word_shifted;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_ONE;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + COUNT_ONE;
                if (word_q == HALT_INST) begin
                    state_d    = DONE;
                    overflow_d = 1'b0;
                end else if (&addr_q) begin
                    state_d    = DONE;
                    overflow_d = 1'b1;
                end else begin
                    state_d    = RECV;
                    addr_d     = addr_q + ADDR_ONE;
                    byte_cnt_d = '0;
                    // A strobe landing in the write cycle becomes byte 0 of the next word.
                    if (rx_done_i) begin
                        word_d     = word_shifted;
                        byte_cnt_d = CNT_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_en_o      = (state_q == WRITE);
    assign done_o       = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign word_count_o = word_count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed and random byte streams scored against a
// word-level model; a second instance with a 4-word memory exercises overflow.
module tb_instruction_loader;

    localparam logic [31:0] HALT = 32'hFC000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_s, rx_done_s;
    logic [7:0] rx_data_s;
    logic       sel;

    logic        wr_en_a, busy_a, done_a, ovf_a;
    logic [9:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [10:0] wc_a;
    logic        wr_en_b, busy_b, done_b, ovf_b;
    logic [1:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [2:0]  wc_b;

    instruction_loader dut_a (
        .clock_i(clk), .reset_i(rst_n), .start_i(start_s & ~sel),
        .rx_done_i(rx_done_s & ~sel), .rx_data_i(rx_data_s),
        .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a),
        .busy_o(busy_a), .done_o(done_a), .word_count_o(wc_a), .overflow_o(ovf_a)
    );

    instruction_loader #(.NB_ADDR(2)) dut_b (
        .clock_i(clk), .reset_i(rst_n), .start_i(start_s & sel),
        .rx_done_i(rx_done_s & sel), .rx_data_i(rx_data_s),
        .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
        .busy_o(busy_b), .done_o(done_b), .word_count_o(wc_b), .overflow_o(ovf_b)
    );

    logic        cur_wr_en, cur_busy, cur_done, cur_ovf;
    logic [9:0]  cur_addr;
    logic [31:0] cur_data;
    logic [10:0] cur_wc;
    assign cur_wr_en = sel ? wr_en_b : wr_en_a;
    assign cur_busy  = sel ? busy_b  : busy_a;
    assign cur_done  = sel ? done_b  : done_a;
    assign cur_ovf   = sel ? ovf_b   : ovf_a;
    assign cur_addr  = sel ? {8'd0, wr_addr_b} : wr_addr_a;
    assign cur_data  = sel ? wr_data_b : wr_data_a;
    assign cur_wc    = sel ? {8'd0, wc_b} : wc_a;

    logic [41:0] mon_q[$];
    int          done_cnt;
    always @(negedge clk) begin
        if (cur_wr_en) mon_q.push_back({cur_addr, cur_data});
        if (cur_done) done_cnt++;
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]  byte_q[$];
    int          gap_q[$];
    logic [31:0] exp_q[$];
    logic        exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_s = b;
        rx_done_s = 1'b1;
        @(posedge clk);
        #1;
        rx_done_s = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int g);
        byte_q.push_back(b);
        gap_q.push_back(g);
    endtask

    task automatic push_word(input logic [31:0] w, input int g, input int g_last);
        for (int b = 0; b < 4; b++)
            push_byte(w[31-8*b -: 8], (b == 3) ? g_last : g);
    endtask

    // Reference: every strobe during a load is a byte; groups of four make words until
    // HALT is written or the memory is full; anything later is ignored.
    task automatic build_model(input int depth);
        logic [31:0] w;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i + 3 < byte_q.size(); i += 4) begin
            w = {byte_q[i], byte_q[i+1], byte_q[i+2], byte_q[i+3]};
            exp_q.push_back(w);
            if (w == HALT) break;
            if (exp_q.size() == depth) begin
                exp_ovf = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_load(input logic s, input int mid_idx);
        int k;
        int t;
        sel = s;
        build_model(s ? 4 : 1024);
        mon_q.delete();
        done_cnt = 0;
        start_s = 1'b1;
        idle(1);
        start_s = 1'b0;
        for (int i = 0; i < byte_q.size(); i++) begin
            send_byte(byte_q[i]);
            k = i / 4;
            if ((i % 4 == 3) && (k < exp_q.size())) begin
                chk("wr_en_latency", cur_wr_en, 1);
                chk("wr_addr", cur_addr, k);
                chk("wr_data", cur_data, exp_q[k]);
                if (k == exp_q.size() - 1) begin
                    idle(1);
                    chk("done_pulse", cur_done, 1);
                    chk("busy_in_done", cur_busy, 1);
                end
            end
            if (i == mid_idx) begin
                start_s = 1'b1;
                idle(1);
                start_s = 1'b0;
            end
            idle(gap_q[i]);
        end
        t = 0;
        while (cur_busy && t < 50) begin
            idle(1);
            t++;
        end
        chk("busy_clear", cur_busy, 0);
        chk("write_count", mon_q.size(), exp_q.size());
        for (int j = 0; j < mon_q.size() && j < exp_q.size(); j++) begin
            chk("mon_addr", mon_q[j][41:32], j);
            chk("mon_data", mon_q[j][31:0], exp_q[j]);
        end
        chk("done_count", done_cnt, 1);
        chk("word_count", cur_wc, exp_q.size());
        chk("overflow", cur_ovf, exp_ovf);
        $display("load sel=%0d bytes=%0d words=%0d ovf=%0d", s, byte_q.size(), exp_q.size(), exp_ovf);
        byte_q.delete();
        gap_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; start_s = 1'b0; rx_done_s = 1'b0; rx_data_s = 8'h00; sel = 1'b0;
        idle(3);
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_wc", wc_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_addr", wr_addr_a, 0);
        chk("rst_data", wr_data_a, 0);
        rst_n = 1'b1;
        idle(1);

        // Bytes while idle must not write.
        mon_q.delete();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(2);
        chk("idle_no_write", mon_q.size(), 0);
        chk("idle_busy", busy_a, 0);

        // Basic load, 10-clock gaps.
        push_word(32'h8C080000, 10, 10);
        push_word(HALT, 10, 10);
        run_load(1'b0, -1);

        // Multi-word load with a start pulse in the middle of word 1.
        push_word(32'h8C080000, 1, 1);
        push_word(32'h8C090004, 1, 1);
        push_word(32'h2911000F, 1, 1);
        push_word(HALT, 1, 1);
        run_load(1'b0, 5);

        // Byte 0 of word 1 arrives in the write cycle of word 0.
        push_word(32'h8C080000, 2, 0);
        push_word(32'h2911000F, 2, 2);
        push_word(HALT, 2, 2);
        run_load(1'b0, -1);

        // Overflow on the 4-word instance; the 5th word is ignored.
        for (int w = 1; w <= 5; w++) push_word(32'(w), 2, 2);
        run_load(1'b1, -1);

        // Reset in the middle of a word.
        sel = 1'b0;
        mon_q.delete();
        start_s = 1'b1; idle(1); start_s = 1'b0;
        send_byte(8'hAA); idle(2);
        send_byte(8'hBB); idle(2);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        chk("midrst_no_write", mon_q.size(), 0);
        chk("midrst_wr_en", wr_en_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_wc", wc_a, 0);
        chk("midrst_data", wr_data_a, 0);
        idle(3);
        chk("midrst_still_idle", mon_q.size(), 0);
        push_word(32'h8C080000, 1, 1);
        push_word(HALT, 1, 1);
        run_load(1'b0, -1);

        // Random loads on both instances.
        for (int r = 0; r < 8; r++) begin
            int  n;
            logic s;
            s = r[0];
            n = s ? $urandom_range(2, 6) : $urandom_range(1, 5);
            if (s && n < 4 && ($urandom_range(0, 1) == 0)) n = 4;
            for (int w = 0; w < n; w++) begin
                logic [31:0] wv;
                wv = $urandom;
                if (w == n - 1 && (!s || n < 4 || $urandom_range(0, 1) == 1)) wv = HALT;
                for (int b = 0; b < 4; b++) push_byte(wv[31-8*b -: 8], $urandom_range(0, 3));
            end
            for (int b = 0; b < 4; b++) push_byte(8'($urandom), $urandom_range(0, 3));
            run_load(s, ($urandom_range(0, 1) == 1) ? 1 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
